seg7x4_anode_to_bin14: RTL and testbench

//  Reads back four common-anode 7-segment display codes and converts them to a
//  14-bit binary value, the reverse of the binary-to-7-segment display path.
//  - Each code is decoded to a BCD digit.
//  - The 4-digit BCD word is converted by sequential reverse double dabble.
//  - The block sits on the display bus for self-check and for readback of user-set values.
//  - It uses a start/busy/done handshake.

---
 rtl/seg7x4_anode_to_bin14_if.sv | 23 ++
 rtl/seg7x4_anode_to_bin14.sv | 135 +++++++++++++
 tb/tb_seg7x4_anode_to_bin14.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7x4_anode_to_bin14_if.sv
// Display-bus bundle for the 7-segment readback converter: request, four
// segment codes, and the result/handshake returned by the converter.
interface seg7x4_anode_to_bin14_if;
    logic        start;
    logic [7:0]  disp0;
    logic [7:0]  disp1;
    logic [7:0]  disp2;
    logic [7:0]  disp3;
    logic [13:0] bin;
    logic        err;
    logic        busy;
    logic        done;

    modport master (
        output start, disp0, disp1, disp2, disp3,
        input  bin, err, busy, done
    );

    modport slave (
        input  start, disp0, disp1, disp2, disp3,
        output bin, err, busy, done
    );
endinterface

// File: rtl/seg7x4_anode_to_bin14.sv
// Converts four common-anode 7-segment codes back to a 14-bit binary value:
// each code is decoded to BCD, then the 4-digit BCD word is turned into
// binary by 14 steps of reverse double dabble (shift right, nibble >= 8 -> -3).
module seg7x4_anode_to_bin14 #(
    parameter bit BLANK_AS_ZERO = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    seg7x4_anode_to_bin14_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_STEP = 4'd13;

    state_t      state_q, state_d;
    logic [29:0] sr_q, sr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [13:0] bin_q, bin_d;
    logic        err_q, err_d;

    logic [3:0]  bcd0, bcd1, bcd2, bcd3;
    logic        ill0, ill1, ill2, ill3;
    logic        any_illegal;
    logic [29:0] sr_step;

    // Decimal point is not part of the digit value.
    logic        dp_unused;
    assign dp_unused = ^{bus.disp0[7], bus.disp1[7], bus.disp2[7], bus.disp3[7]};

    // Returns {illegal, bcd} for one active-low [6:0] segment pattern.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h40:   r = {1'b0, 4'd0};
            7'h79:   r = {1'b0, 4'd1};
            7'h24:   r = {1'b0, 4'd2};
            7'h30:   r = {1'b0, 4'd3};
            7'h19:   r = {1'b0, 4'd4};
            7'h12:   r = {1'b0, 4'd5};
            7'h02:   r = {1'b0, 4'd6};
            7'h78:   r = {1'b0, 4'd7};
            7'h00:   r = {1'b0, 4'd8};
            7'h10:   r = {1'b0, 4'd9};
            7'h7F:   r = {~BLANK_AS_ZERO, 4'd0};
            default: r = {1'b1, 4'd0};
        endcase
        return r;
    endfunction

    // Decode all four digits and flag any illegal code.
    always_comb begin
        {ill0, bcd0} = seg_decode(bus.disp0[6:0]);
        {ill1, bcd1} = seg_decode(bus.disp1[6:0]);
        {ill2, bcd2} = seg_decode(bus.disp2[6:0]);
        {ill3, bcd3} = seg_decode(bus.disp3[6:0]);
        any_illegal  = ill0 | ill1 | ill2 | ill3;
    end

    // One reverse double-dabble step: shift right, then correct BCD nibbles.
    always_comb begin
        sr_step = sr_q >> 1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (sr_step[14 + 4*i +: 4] >= 4'd8) begin
                sr_step[14 + 4*i +: 4] = sr_step[14 + 4*i +: 4] - 4'd3;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath update for IDLE -> CONV/DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (any_illegal) begin
                        err_d   = 1'b1;
                        bin_d   = '0;
                        state_d = DONE;
                    end else begin
                        sr_d    = {bcd3, bcd2, bcd1, bcd0, 14'd0};
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                sr_d  = sr_step;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_STEP) begin
                    bin_d   = sr_step[13:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.bin  = bin_q;
    assign bus.err  = err_q;
    assign bus.busy = (state_q == CONV);
    assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_seg7x4_anode_to_bin14.sv
// Scoreboard bench: two converters (blank-as-zero on and off) share one
// stimulus stream; a decimal reference model predicts value, error flag and
// done cycle, and per-DUT monitors compare whenever done is seen.
module tb_seg7x4_anode_to_bin14;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg7x4_anode_to_bin14_if bus_a ();
    seg7x4_anode_to_bin14_if bus_b ();

    seg7x4_anode_to_bin14 #(.BLANK_AS_ZERO(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    seg7x4_anode_to_bin14 #(.BLANK_AS_ZERO(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    assign bus_b.start = bus_a.start;
    assign bus_b.disp0 = bus_a.disp0;
    assign bus_b.disp1 = bus_a.disp1;
    assign bus_b.disp2 = bus_a.disp2;
    assign bus_b.disp3 = bus_a.disp3;

    localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [6:0] BLANK = 7'h7F;

    typedef struct {
        logic [13:0] bin;
        logic        err;
        int unsigned cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned fails = 0;
    int unsigned busy_a = 0;
    int unsigned busy_b = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] s);
        if (s == BLANK) return 1'b1;
        for (int k = 0; k < 10; k++) if (s == SEG[k]) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: read the four glyphs as a decimal number.
    function automatic void model(input logic [31:0] codes, input bit blank_zero,
                                  output logic err, output logic [13:0] bin);
        int value;
        logic [6:0] s;
        int dig;
        value = 0;
        err   = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            s   = codes[8*i +: 7];
            dig = -1;
            for (int k = 0; k < 10; k++) if (s == SEG[k]) dig = k;
            if (s == BLANK && blank_zero) dig = 0;
            if (dig < 0) err = 1'b1;
            else value = value * 10 + dig;
        end
        bin = err ? 14'd0 : 14'(value);
    endfunction

    // d = -1 encodes a blank digit; dp sets the decimal-point bit on every digit.
    function automatic logic [31:0] enc(input int d3, input int d2, input int d1, input int d0, input bit dp);
        int d [4];
        logic [31:0] c;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        for (int i = 0; i < 4; i++) begin
            c[8*i +: 7] = (d[i] < 0) ? BLANK : SEG[d[i]];
            c[8*i + 7]  = dp;
        end
        return c;
    endfunction

    task automatic set_codes(input logic [31:0] codes);
        bus_a.disp0 = codes[7:0];
        bus_a.disp1 = codes[15:8];
        bus_a.disp2 = codes[23:16];
        bus_a.disp3 = codes[31:24];
    endtask

    task automatic push_exp(input logic [31:0] codes, input int unsigned base);
        exp_t e;
        model(codes, 1'b1, e.err, e.bin);
        e.cyc = base + (e.err ? 1 : 15);
        qa.push_back(e);
        model(codes, 1'b0, e.err, e.bin);
        e.cyc = base + (e.err ? 1 : 15);
        qb.push_back(e);
    endtask

    // Called at a negedge with the DUTs idle; start is sampled at the next posedge.
    task automatic issue(input logic [31:0] codes);
        set_codes(codes);
        bus_a.start = 1'b1;
        push_exp(codes, cyc);
        @(negedge clk);
        bus_a.start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
        check("drain_a_pending", qa.size(), 0);
        check("drain_b_pending", qb.size(), 0);
        qa.delete();
        qb.delete();
        repeat (2) @(negedge clk);
    endtask

    // Monitor for the blank-as-zero converter.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_a = 0;
        end else begin
            if (bus_a.busy) busy_a++;
            if (bus_a.done) begin
                if (qa.size() == 0) begin
                    check("a_spurious_done", bus_a.done, 0);
                end else begin
                    e = qa.pop_front();
                    check("a_bin", bus_a.bin, e.bin);
                    check("a_err", bus_a.err, e.err);
                    check("a_done_cycle", cyc, e.cyc);
                    check("a_busy_cycles", busy_a, e.err ? 0 : 14);
                    check("a_busy_in_done", bus_a.busy, 0);
                end
                busy_a = 0;
            end
        end
    end

    // Monitor for the blank-is-error converter.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_b = 0;
        end else begin
            if (bus_b.busy) busy_b++;
            if (bus_b.done) begin
                if (qb.size() == 0) begin
                    check("b_spurious_done", bus_b.done, 0);
                end else begin
                    e = qb.pop_front();
                    check("b_bin", bus_b.bin, e.bin);
                    check("b_err", bus_b.err, e.err);
                    check("b_done_cycle", cyc, e.cyc);
                    check("b_busy_cycles", busy_b, e.err ? 0 : 14);
                end
                busy_b = 0;
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_a_bin"},  bus_a.bin, 0);
        check({tag, "_a_err"},  bus_a.err, 0);
        check({tag, "_a_busy"}, bus_a.busy, 0);
        check({tag, "_a_done"}, bus_a.done, 0);
        check({tag, "_b_bin"},  bus_b.bin, 0);
        check({tag, "_b_err"},  bus_b.err, 0);
        check({tag, "_b_busy"}, bus_b.busy, 0);
        check({tag, "_b_done"}, bus_b.done, 0);
    endtask

    function automatic logic [7:0] rand_digit_code();
        int unsigned r;
        logic [6:0] s;
        r = $urandom_range(0, 19);
        if (r < 16) s = SEG[$urandom_range(0, 9)];
        else if (r < 19) s = BLANK;
        else begin
            s = 7'($urandom);
            while (is_legal(s)) s = 7'($urandom);
        end
        return {1'($urandom), s};
    endfunction

    initial begin
        logic [31:0] codes;
        bus_a.start = 1'b0;
        set_codes('0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        issue(enc(1, 2, 3, 4, 1'b0)); drain();
        issue(enc(9, 9, 9, 9, 1'b0)); drain();
        issue(enc(0, 0, 0, 0, 1'b0)); drain();
        issue(enc(9, 9, 9, 9, 1'b1)); drain();
        issue(enc(1, 2, 3, 4, 1'b1)); drain();
        issue(enc(-1, -1, 4, 2, 1'b0)); drain();
        codes = enc(5, 6, 7, 8, 1'b0);
        codes[23:16] = 8'h08;
        issue(codes); drain();
        issue(enc(0, 8, 0, 7, 1'b0)); drain();

        // Start and changed inputs during a conversion are ignored.
        issue(enc(3, 1, 4, 1, 1'b0));
        repeat (4) @(negedge clk);
        set_codes(enc(2, 7, 1, 8, 1'b0));
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        drain();

        // Held-high start restarts on the first idle cycle after done.
        codes = enc(6, 5, 4, 3, 1'b0);
        set_codes(codes);
        bus_a.start = 1'b1;
        push_exp(codes, cyc);
        push_exp(codes, cyc + 16);
        repeat (20) @(negedge clk);
        bus_a.start = 1'b0;
        drain();

        // Reset in the middle of a conversion.
        issue(enc(8, 7, 6, 5, 1'b0));
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero_outputs("midreset");
        qa.delete();
        qb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        issue(enc(0, 0, 0, 5, 1'b0)); drain();

        // Randomized codes, including blanks, DP bits and illegal glyphs.
        for (int n = 0; n < 60; n++) begin
            codes = {rand_digit_code(), rand_digit_code(), rand_digit_code(), rand_digit_code()};
            issue(codes);
            drain();
        end

        check("final_a_queue", qa.size(), 0);
        check("final_b_queue", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
